// File: rtl/idu_pkg.sv
// Shared state encoding, header layout and header legality check for the
// IDU dispatch stage.
package idu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    REQ,
    DISPATCH,
    DROP
  } state_t;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_W   = 8;
  localparam int unsigned NB_LSB  = 8;
  localparam int unsigned NB_W    = 3;
  localparam int unsigned CH_LSB  = 12;
  localparam int unsigned CH_W    = 3;

  typedef logic [OPC_LSB+OPC_W-1:OPC_LSB] opcode_t;
  typedef logic [NB_W-1:0]                nbeats_t;
  typedef logic [CH_W-1:0]                ch_id_t;

  // A header is usable only if its beat count fits the buffer and its channel exists.
  function automatic logic hdr_legal(input nbeats_t     nbeats,
                                     input ch_id_t      ch_id,
                                     input int unsigned max_beats,
                                     input int unsigned num_ch);
    return (nbeats != '0) && (32'(nbeats) <= max_beats) && (32'(ch_id) < num_ch);
  endfunction

endpackage

// File: rtl/idu_inflight_cnt.sv
// Saturating up/down counter of instructions in flight on one engine channel.
module idu_inflight_cnt
  import idu_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_d;

  // Simultaneous inc and dec cancel; both ends saturate.
  always_comb begin
    count_d = count;
    if (inc && !dec) begin
      if (count != CNT_MAX) count_d = count + CNT_W'(1);
    end else if (dec && !inc) begin
      if (count != '0) count_d = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      nonzero <= 1'b0;
    end else begin
      count   <= count_d;
      nonzero <= (count_d != '0);
    end
  end

endmodule

// File: rtl/idu_dispatch_unit.sv
// Instruction decode/dispatch: assembles a header plus payload words from the
// IFU FIFO into one wide instruction and writes it to the selected engine FIFO.
module idu_dispatch_unit
  import idu_pkg::*;
#(
  parameter  int unsigned WORD_W    = 64,
  parameter  int unsigned MAX_BEATS = 4,
  parameter  int unsigned NUM_CH    = 3,
  parameter  int unsigned CNT_W     = 4,
  localparam int unsigned INSTR_W   = WORD_W * MAX_BEATS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_empty,
  output logic                    ifu_rd_rqst,
  input  logic [WORD_W-1:0]       ifu_rd_data,
  input  logic                    ifu_rd_data_vld,
  input  logic [NUM_CH-1:0]       ch_full,
  output logic [NUM_CH-1:0]       ch_wr_en,
  output logic [INSTR_W-1:0]      ch_wr_data,
  input  logic [NUM_CH-1:0]       ch_done,
  output logic [NUM_CH*CNT_W-1:0] ch_inflight,
  output logic [NUM_CH-1:0]       ch_busy,
  output logic                    err_illegal,
  output logic                    busy
);

  state_t               state_q, state_d;
  nbeats_t              beat_q, beat_d;
  nbeats_t              nbeats_q, nbeats_d;
  ch_id_t               ch_id_q, ch_id_d;
  logic [INSTR_W-1:0]   asm_q, asm_d;
  logic [INSTR_W-1:0]   asm_masked;
  logic [INSTR_W-1:0]   wr_data_d;
  logic [NUM_CH-1:0]    wr_en_d;
  logic [NUM_CH-1:0]    ch_sel;
  logic                 full_sel;
  logic                 rqst_d;
  logic                 err_d;
  nbeats_t              hdr_nb;
  ch_id_t               hdr_ch;

  assign hdr_nb = ifu_rd_data[NB_LSB +: NB_W];
  assign hdr_ch = ifu_rd_data[CH_LSB +: CH_W];

  // One-hot target channel and its full flag, from the latched header.
  always_comb begin
    ch_sel   = '0;
    full_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_id_q == CH_W'(i)) begin
        ch_sel[i] = 1'b1;
        full_sel  = ch_full[i];
      end
    end
  end

  // Slots beyond the instruction length may hold words of an older, longer one.
  always_comb begin
    asm_masked = '0;
    for (int unsigned i = 0; i < MAX_BEATS; i++) begin
      if (32'(nbeats_q) > i) asm_masked[i*WORD_W +: WORD_W] = asm_q[i*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    nbeats_d  = nbeats_q;
    ch_id_d   = ch_id_q;
    asm_d     = asm_q;
    wr_data_d = ch_wr_data;
    wr_en_d   = '0;
    rqst_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!ifu_empty) begin
          rqst_d  = 1'b1;
          beat_d  = '0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (ifu_rd_data_vld) begin
          for (int unsigned i = 0; i < MAX_BEATS; i++) begin
            if (beat_q == NB_W'(i)) asm_d[i*WORD_W +: WORD_W] = ifu_rd_data;
          end
          if (beat_q == '0) begin
            nbeats_d = hdr_nb;
            ch_id_d  = hdr_ch;
            if (!hdr_legal(hdr_nb, hdr_ch, MAX_BEATS, NUM_CH)) begin
              state_d = DROP;
            end else if (hdr_nb == NB_W'(1)) begin
              state_d = DISPATCH;
            end else begin
              beat_d  = beat_q + NB_W'(1);
              state_d = REQ;
            end
          end else if (beat_q == nbeats_q - NB_W'(1)) begin
            state_d = DISPATCH;
          end else begin
            beat_d  = beat_q + NB_W'(1);
            state_d = REQ;
          end
        end
      end

      REQ: begin
        if (!ifu_empty) begin
          rqst_d  = 1'b1;
          state_d = WAIT;
        end
      end

      DISPATCH: begin
        if (!full_sel) begin
          wr_en_d   = ch_sel;
          wr_data_d = asm_masked;
          state_d   = IDLE;
        end
      end

      DROP: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      nbeats_q    <= '0;
      ch_id_q     <= '0;
      asm_q       <= '0;
      ifu_rd_rqst <= 1'b0;
      ch_wr_en    <= '0;
      ch_wr_data  <= '0;
      err_illegal <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      nbeats_q    <= nbeats_d;
      ch_id_q     <= ch_id_d;
      asm_q       <= asm_d;
      ifu_rd_rqst <= rqst_d;
      ch_wr_en    <= wr_en_d;
      ch_wr_data  <= wr_data_d;
      err_illegal <= err_d;
      busy        <= (state_d != IDLE);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    idu_inflight_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (ch_wr_en[g]),
      .dec    (ch_done[g]),
      .count  (ch_inflight[g*CNT_W +: CNT_W]),
      .nonzero(ch_busy[g])
    );
  end

endmodule

// File: tb/tb_idu_dispatch_unit.sv
// Directed bench for idu_dispatch_unit; the IFU FIFO is modelled with data
// returning the cycle after each read request.
module tb_idu_dispatch_unit;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned MAX_BEATS = 4;
  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned INSTR_W   = WORD_W * MAX_BEATS;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    ifu_empty = 1'b1;
  logic                    ifu_rd_rqst;
  logic [WORD_W-1:0]       ifu_rd_data = '0;
  logic                    ifu_rd_data_vld = 1'b0;
  logic [NUM_CH-1:0]       ch_full = '0;
  logic [NUM_CH-1:0]       ch_wr_en;
  logic [INSTR_W-1:0]      ch_wr_data;
  logic [NUM_CH-1:0]       ch_done = '0;
  logic [NUM_CH*CNT_W-1:0] ch_inflight;
  logic [NUM_CH-1:0]       ch_busy;
  logic                    err_illegal;
  logic                    busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [WORD_W-1:0] ifu_q[$];
  logic              pend = 1'b0;
  logic [WORD_W-1:0] pend_data = '0;

  int                 cyc = 0;
  int                 n_rqst = 0;
  int                 n_err = 0;
  int                 n_wr = 0;
  int                 last_wr_cyc = 0;
  int                 rq_cyc[$];
  logic [NUM_CH-1:0]  last_en = '0;
  logic [INSTR_W-1:0] last_data = '0;

  idu_dispatch_unit #(
    .WORD_W   (WORD_W),
    .MAX_BEATS(MAX_BEATS),
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_empty      (ifu_empty),
    .ifu_rd_rqst    (ifu_rd_rqst),
    .ifu_rd_data    (ifu_rd_data),
    .ifu_rd_data_vld(ifu_rd_data_vld),
    .ch_full        (ch_full),
    .ch_wr_en       (ch_wr_en),
    .ch_wr_data     (ch_wr_data),
    .ch_done        (ch_done),
    .ch_inflight    (ch_inflight),
    .ch_busy        (ch_busy),
    .err_illegal    (err_illegal),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // IFU FIFO: pop on request, present the word as valid during the next cycle.
  always @(negedge clk) begin
    ifu_rd_data_vld = pend;
    if (pend) ifu_rd_data = pend_data;
    pend = (ifu_rd_rqst === 1'b1);
    if (pend) begin
      if (ifu_q.size() != 0) pend_data = ifu_q.pop_front();
      else pend_data = '0;
    end
    ifu_empty = (ifu_q.size() == 0);
  end

  always @(negedge clk) begin
    cyc++;
    if (ifu_rd_rqst === 1'b1) begin
      n_rqst++;
      rq_cyc.push_back(cyc);
    end
    if (err_illegal === 1'b1) n_err++;
    if (ch_wr_en != '0) begin
      n_wr++;
      last_en     = ch_wr_en;
      last_data   = ch_wr_data;
      last_wr_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [INSTR_W-1:0] got,
                       input logic [INSTR_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(input string tag, input int target);
    int k = 0;
    while (n_wr < target && k < 200) begin
      tick(1);
      k++;
    end
    check({tag, "_wr_seen"}, (n_wr >= target), 1'b1);
  endtask

  task automatic wait_rqst(input string tag, input int target);
    int k = 0;
    while (n_rqst < target && k < 200) begin
      tick(1);
      k++;
    end
    check({tag, "_rqst_seen"}, (n_rqst >= target), 1'b1);
  endtask

  initial begin
    int base, r0, r1, e0, c0, seen, k;

    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_wr_en", ch_wr_en, '0);
    check("rst_rqst", ifu_rd_rqst, '0);
    check("rst_busy_err", {busy, err_illegal}, '0);
    check("rst_inflight", {ch_inflight, ch_busy}, '0);
    check("rst_wr_data", ch_wr_data, '0);

    // Two-beat instruction to channel 0.
    base = n_wr; r0 = n_rqst;
    ifu_q.push_back(64'h201);
    ifu_q.push_back(64'hA5);
    wait_wr("t1", base + 1);
    check("t1_en", last_en, 3'b001);
    check("t1_data", last_data, {64'h0, 64'h0, 64'hA5, 64'h201});
    check("t1_latency", last_wr_cyc - rq_cyc[r0], 6);
    tick(2);
    check("t1_cnt", ch_inflight[3:0], 4'd1);
    check("t1_ch_busy", ch_busy, 3'b001);
    check("t1_idle", busy, 1'b0);

    // Three-beat to channel 1 against a full FIFO, with more work queued.
    ch_full = 3'b010;
    base = n_wr; r0 = n_rqst;
    ifu_q.push_back(64'h1333);
    ifu_q.push_back(64'h11);
    ifu_q.push_back(64'h22);
    wait_rqst("t2", r0 + 3);
    tick(4);
    ifu_q.push_back(64'h17E);
    r1 = n_rqst;
    tick(5);
    check("t2_stall_wr", n_wr, base);
    check("t2_stall_rqst", n_rqst, r1);
    check("t2_stall_busy", busy, 1'b1);
    ch_full = '0;
    c0 = cyc;
    wait_wr("t2", base + 1);
    check("t2_en", last_en, 3'b010);
    check("t2_data", last_data, {64'h0, 64'h22, 64'h11, 64'h1333});
    check("t2_wr_cycle", last_wr_cyc, c0 + 2);
    wait_wr("t2b", base + 2);
    check("t2b_en", last_en, 3'b001);
    check("t2b_data_masked", last_data, {192'h0, 64'h17E});

    // Illegal headers: bad channel, zero beats, too many beats.
    base = n_wr; r0 = n_rqst; e0 = n_err;
    ifu_q.push_back(64'h5255);
    ifu_q.push_back(64'h0011);
    ifu_q.push_back(64'h0512);
    wait_rqst("t3", r0 + 3);
    tick(6);
    check("t3_err_pulses", n_err - e0, 3);
    check("t3_rqst_count", n_rqst - r0, 3);
    check("t3_no_write", n_wr - base, 0);
    check("t3_idle", busy, 1'b0);
    ifu_q.push_back(64'h2266);
    ifu_q.push_back(64'hBEEF);
    wait_wr("t3b", base + 1);
    check("t3b_en", last_en, 3'b100);
    check("t3b_data", last_data, {128'h0, 64'hBEEF, 64'h2266});

    // Four-beat instruction with the IFU empty after the header.
    base = n_wr; r0 = n_rqst;
    ifu_q.push_back(64'h1444);
    wait_rqst("t4", r0 + 1);
    tick(8);
    check("t4_hold_rqst", n_rqst - r0, 1);
    check("t4_hold_busy", busy, 1'b1);
    ifu_q.push_back(64'hA1);
    ifu_q.push_back(64'hA2);
    ifu_q.push_back(64'hA3);
    wait_wr("t4", base + 1);
    check("t4_en", last_en, 3'b010);
    check("t4_data", last_data, {64'hA3, 64'hA2, 64'hA1, 64'h1444});

    // Channel 2 counter: reach 3, then write and done in the same cycle.
    base = n_wr;
    ifu_q.push_back(64'h2101);
    ifu_q.push_back(64'h2102);
    wait_wr("t5a", base + 2);
    tick(2);
    check("t5_cnt3", ch_inflight[11:8], 4'd3);
    ch_full = 3'b100;
    base = n_wr; r0 = n_rqst;
    ifu_q.push_back(64'h2103);
    wait_rqst("t5b", r0 + 1);
    tick(4);
    ch_full = '0;
    tick(1);
    ch_done = 3'b100;
    c0 = cyc;
    tick(1);
    ch_done = '0;
    tick(2);
    check("t5_coincide_wr", n_wr - base, 1);
    check("t5_coincide_cycle", last_wr_cyc, c0 + 1);
    check("t5_cnt_hold", ch_inflight[11:8], 4'd3);

    base = n_wr;
    for (int i = 0; i < 16; i++) ifu_q.push_back(64'h2100 | 64'(i));
    wait_wr("t5c", base + 16);
    tick(2);
    check("t5_sat", ch_inflight[11:8], 4'd15);
    ch_done = 3'b100;
    tick(1);
    ch_done = '0;
    tick(2);
    check("t5_dec", ch_inflight[11:8], 4'd14);

    ch_done = 3'b001;
    tick(2);
    ch_done = '0;
    tick(2);
    check("t5_ch0_zero", ch_inflight[3:0], 4'd0);
    ch_done = 3'b001;
    tick(2);
    ch_done = '0;
    tick(2);
    check("t5_ch0_floor", ch_inflight[3:0], 4'd0);
    check("t5_ch_busy", ch_busy, 3'b110);
    check("t5_ch1_cnt", ch_inflight[7:4], 4'd2);

    // Reset while waiting for beat 1 of a three-beat instruction.
    ifu_q.push_back(64'h377);
    ifu_q.push_back(64'hF00D);
    seen = 0; k = 0;
    while (seen < 2 && k < 50) begin
      tick(1);
      k++;
      if (ifu_rd_rqst === 1'b1) seen++;
    end
    check("t6_reach_beat1", seen, 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_rst_wr_en", ch_wr_en, '0);
    check("t6_rst_flags", {ifu_rd_rqst, err_illegal, busy}, '0);
    check("t6_rst_inflight", {ch_inflight, ch_busy}, '0);
    check("t6_rst_wr_data", ch_wr_data, '0);
    r0 = n_rqst; base = n_wr;
    tick(4);
    check("t6_stale_idle", busy, 1'b0);
    check("t6_stale_rqst", n_rqst - r0, 0);
    ifu_q.push_back(64'h1288);
    ifu_q.push_back(64'h99);
    wait_wr("t6", base + 1);
    check("t6_en", last_en, 3'b010);
    check("t6_data", last_data, {128'h0, 64'h99, 64'h1288});
    tick(2);
    check("t6_inflight", ch_inflight, 12'h010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
    $fatal(1);
  end

endmodule
